// File: rtl/nios_system_ledg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_ledg_pkg
// Purpose  : Shared encodings for the green LED sequencer (modes, register
//            map, CTRL/STATUS bit positions, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package nios_system_ledg_pkg;

    localparam logic [1:0] c_MODE_STATIC = 2'd0;
    localparam logic [1:0] c_MODE_BLINK  = 2'd1;
    localparam logic [1:0] c_MODE_CHASE  = 2'd2;
    localparam logic [1:0] c_MODE_BAR    = 2'd3;

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_CTRL   = 2'd1;
    localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    localparam int c_CTRL_MODE_LSB   = 0;
    localparam int c_CTRL_RUN        = 2;
    localparam int c_CTRL_IE         = 3;
    localparam int c_CTRL_W          = 4;

    localparam int c_STATUS_DONE     = 0;
    localparam int c_STATUS_BUSY     = 1;
    localparam int c_STATUS_STEP_LSB = 4;
    localparam int c_STEP_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nios_system_ledg_tick.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_ledg_tick
// Purpose  : Step prescaler; counts 0..period and pulses tick on the wrap.
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_ledg_tick #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] r_count;
    logic                w_wrap;

    assign w_wrap = (r_count == period);
    // A clear on the same edge swallows the tick so a CTRL write always wins.
    assign tick   = enable & ~clear & w_wrap;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nios_system_ledg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nios_system_ledg_sequencer
// Purpose  : Avalon-MM LED sequencer (static/blink/chase/fill-bar) driving LEDG.
// Revision : 1.0 - initial release
// ============================================================================
module nios_system_ledg_sequencer
    import nios_system_ledg_pkg::*;
#(
    parameter int          WIDTH      = 9,
    parameter int          PERIOD_W   = 26,
    parameter int unsigned PERIOD_RST = 12500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0]    r_data, r_work, r_out;
    logic [c_CTRL_W-1:0] r_ctrl;
    logic [PERIOD_W-1:0] r_period;
    logic [c_STEP_W-1:0] r_step;
    logic                r_phase, r_done;
    state_t              r_state;

    logic [WIDTH-1:0]    w_data_n, w_work_n, w_out_n;
    logic [c_CTRL_W-1:0] w_ctrl_n;
    logic [c_STEP_W-1:0] w_step_n, w_step_inc;
    logic                w_phase_n, w_done_n;
    state_t              w_state_n;
    logic [WIDTH:0]      w_bar_full;
    logic                w_wr, w_wr_data, w_wr_ctrl, w_wr_period, w_wr_status;
    logic                w_tick;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr && (address == c_ADDR_DATA);
    assign w_wr_ctrl   = w_wr && (address == c_ADDR_CTRL);
    assign w_wr_period = w_wr && (address == c_ADDR_PERIOD);
    assign w_wr_status = w_wr && (address == c_ADDR_STATUS);

    nios_system_ledg_tick #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (r_state == RUN),
        .clear   (w_wr_ctrl | w_wr_period),
        .period  (r_period),
        .tick    (w_tick)
    );

    assign w_step_inc = r_step + 1'b1;
    assign w_bar_full = ((WIDTH+1)'(1) << w_step_n) - 1'b1;

    always_comb begin
        w_data_n  = w_wr_data ? writedata[WIDTH-1:0] : r_data;
        w_ctrl_n  = r_ctrl;
        w_state_n = r_state;
        w_step_n  = r_step;
        w_phase_n = r_phase;
        w_work_n  = r_work;
        w_done_n  = r_done;
        w_out_n   = r_out;

        if (w_wr_ctrl) begin
            w_ctrl_n  = writedata[c_CTRL_W-1:0];
            w_step_n  = '0;
            w_phase_n = 1'b0;
            w_work_n  = r_data;
            w_done_n  = 1'b0;
            w_state_n = writedata[c_CTRL_RUN] ? RUN : IDLE;
        end else begin
            if (w_wr_status && writedata[c_STATUS_DONE]) begin
                w_done_n = 1'b0;
            end
            // Completion is evaluated after the clear so a racing clear loses.
            if (r_state == RUN && w_tick) begin
                unique case (r_ctrl[c_CTRL_MODE_LSB +: 2])
                    c_MODE_BLINK: w_phase_n = ~r_phase;
                    c_MODE_CHASE: w_work_n  = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                    c_MODE_BAR: begin
                        w_step_n = w_step_inc;
                        if (w_step_inc == c_STEP_W'(WIDTH)) begin
                            w_state_n = DONE;
                            w_done_n  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        unique case (w_state_n)
            RUN: begin
                unique case (w_ctrl_n[c_CTRL_MODE_LSB +: 2])
                    c_MODE_BLINK: w_out_n = w_phase_n ? '0 : w_data_n;
                    c_MODE_CHASE: w_out_n = w_work_n;
                    c_MODE_BAR:   w_out_n = w_bar_full[WIDTH-1:0];
                    default:      w_out_n = w_data_n;
                endcase
            end
            DONE:    w_out_n = '1;
            default: w_out_n = w_data_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_ctrl   <= '0;
            r_period <= PERIOD_W'(PERIOD_RST);
            r_state  <= IDLE;
            r_step   <= '0;
            r_phase  <= 1'b0;
            r_work   <= '0;
            r_done   <= 1'b0;
            r_out    <= '0;
        end else begin
            r_data   <= w_data_n;
            r_ctrl   <= w_ctrl_n;
            r_period <= w_wr_period ? writedata[PERIOD_W-1:0] : r_period;
            r_state  <= w_state_n;
            r_step   <= w_step_n;
            r_phase  <= w_phase_n;
            r_work   <= w_work_n;
            r_done   <= w_done_n;
            r_out    <= w_out_n;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            c_ADDR_DATA:   readdata = 32'(r_data);
            c_ADDR_CTRL:   readdata = 32'(r_ctrl);
            c_ADDR_PERIOD: readdata = 32'(r_period);
            default: begin
                readdata[c_STATUS_DONE]                  = r_done;
                readdata[c_STATUS_BUSY]                  = (r_state == RUN);
                readdata[c_STATUS_STEP_LSB +: c_STEP_W]  = r_step;
            end
        endcase
    end

    assign out_port = r_out;
    assign irq      = r_done & r_ctrl[c_CTRL_IE];

endmodule
`default_nettype wire

// File: tb/tb_nios_system_ledg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_system_ledg_sequencer
// Purpose  : Directed self-checking bench for the LED sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_system_ledg_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [8:0]  out_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    nios_system_ledg_sequencer #(
        .WIDTH      (9),
        .PERIOD_W   (26),
        .PERIOD_RST (12500000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the write edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [8:0] chase_exp [9];

    initial begin
        chase_exp = '{9'h003, 9'h006, 9'h00C, 9'h018, 9'h030,
                      9'h060, 9'h0C0, 9'h180, 9'h101};
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        cyc(2);
        reset_n = 1'b1;

        // Reset state
        rd("rst_data",   2'd0, 32'd0);
        rd("rst_ctrl",   2'd1, 32'd0);
        rd("rst_period", 2'd2, 32'd12500000);
        rd("rst_status", 2'd3, 32'd0);
        check("rst_out", 32'(out_port), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // STATIC
        wr(2'd0, 32'h155);
        check("idle_out", 32'(out_port), 32'h155);
        wr(2'd1, 32'h4);
        check("static_out", 32'(out_port), 32'h155);
        wr(2'd0, 32'h0AA);
        check("static_upd", 32'(out_port), 32'h0AA);
        rd("static_status", 2'd3, 32'h02);
        rd("ctrl_readback", 2'd1, 32'h4);

        // BLINK, PERIOD=3 -> 4 cycles per phase
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1FF);
        wr(2'd1, 32'h5);
        check("blink_0", 32'(out_port), 32'h1FF);
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            check($sformatf("blink_%0d", i), 32'(out_port),
                  (((i / 4) % 2) == 0) ? 32'h1FF : 32'h000);
        end

        // CHASE, PERIOD=0 -> one step per cycle
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h101);
        wr(2'd1, 32'h6);
        check("chase_0", 32'(out_port), 32'h101);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            check($sformatf("chase_%0d", i + 1), 32'(out_port), 32'(chase_exp[i]));
        end

        // BAR, PERIOD=1, ie=1 -> one step every 2 cycles
        wr(2'd2, 32'd1);
        wr(2'd1, 32'hF);
        check("bar_0", 32'(out_port), 32'h000);
        rd("bar_status0", 2'd3, 32'h02);
        for (int s = 1; s <= 9; s++) begin
            cyc(1);
            check($sformatf("bar_hold_%0d", s), 32'(out_port), (32'd1 << (s - 1)) - 1);
            cyc(1);
            check($sformatf("bar_%0d", s), 32'(out_port), (32'd1 << s) - 1);
        end
        rd("bar_done_status", 2'd3, 32'h91);
        check("bar_irq", 32'(irq), 32'd1);
        cyc(1);
        check("done_hold", 32'(out_port), 32'h1FF);
        wr(2'd3, 32'h1);
        check("done_clr_irq", 32'(irq), 32'd0);
        rd("done_clr_status", 2'd3, 32'h90);

        // CTRL write coincident with a tick restarts from step 0
        wr(2'd1, 32'hF);
        cyc(1);
        wr(2'd1, 32'hF);
        check("restart_out", 32'(out_port), 32'h000);
        rd("restart_status", 2'd3, 32'h02);
        cyc(1);
        check("restart_hold", 32'(out_port), 32'h000);
        cyc(1);
        check("restart_step1", 32'(out_port), 32'h001);

        // Reset mid-BAR at step 5
        cyc(8);
        check("bar_step5", 32'(out_port), 32'h01F);
        rd("step5_status", 2'd3, 32'h52);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        check("mid_rst_out", 32'(out_port), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        rd("mid_rst_status", 2'd3, 32'd0);
        rd("mid_rst_period", 2'd2, 32'd12500000);
        rd("mid_rst_ctrl",   2'd1, 32'd0);

        // Done-clear on the completion edge: completion wins
        wr(2'd2, 32'd1);
        wr(2'd1, 32'hF);
        cyc(17);
        check("race_pre", 32'(out_port), 32'h0FF);
        wr(2'd3, 32'h1);
        check("race_out", 32'(out_port), 32'h1FF);
        rd("race_status", 2'd3, 32'h91);
        check("race_irq", 32'(irq), 32'd1);

        // CTRL write with run=0 from DONE returns to IDLE showing DATA
        wr(2'd0, 32'h0F0);
        wr(2'd1, 32'h0);
        check("idle_return", 32'(out_port), 32'h0F0);
        rd("idle_status", 2'd3, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
